// File: rtl/dsi_pixel_fetch_pkg.sv
// Shared definitions for the DSI pixel fetch block: host register map,
// fetch state encoding, STATUS layout and the line/frame tag helper.
package dsi_pixel_fetch_pkg;

    localparam logic [3:0] REG_FETCH_CTL    = 4'h8;
    localparam logic [3:0] REG_FETCH_XSIZE  = 4'h9;
    localparam logic [3:0] REG_FETCH_YSIZE  = 4'hA;
    localparam logic [3:0] REG_FETCH_STATUS = 4'hB;

    localparam int STATUS_ERR_BIT = 0;
    localparam int STATUS_CNT_LSB = 16;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_VS_HI = 3'd1,
        ST_WAIT_VS_LO = 3'd2,
        ST_FETCH      = 3'd3,
        ST_DRAIN      = 3'd4
    } fetch_state_e;

    // Field order matches the upper bits of a stored buffer entry.
    typedef struct packed {
        logic eof;
        logic eol;
        logic sol;
        logic sof;
    } pix_tags_t;

    // Tags of the word at position (x, y) in a frame of (xmax+1) x (ymax+1).
    function automatic pix_tags_t calc_tags(input logic [11:0] x, input logic [11:0] y,
                                            input logic [11:0] xmax, input logic [11:0] ymax);
        pix_tags_t t;
        t.sol = (x == 12'd0);
        t.eol = (x == xmax);
        t.sof = (x == 12'd0) && (y == 12'd0);
        t.eof = (x == xmax) && (y == ymax);
        return t;
    endfunction

endpackage

// File: rtl/dsi_skid_buffer.sv
// Two-entry skid buffer. The head entry is always the oldest word and is
// presented directly; flush drops everything without touching the data.
module dsi_skid_buffer #(
    parameter int g_width = 28
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               push,
    input  logic [g_width-1:0] din,
    input  logic               pop,
    output logic [g_width-1:0] dout,
    output logic [1:0]         occupancy
);

    logic [g_width-1:0] head_r;
    logic [g_width-1:0] tail_r;
    logic [1:0]         occ_r;
    logic               pop_ok_s;
    logic               push_ok_s;

    assign pop_ok_s  = pop && (occ_r != 2'd0);
    assign push_ok_s = push && ((occ_r != 2'd2) || pop_ok_s);
    assign dout      = head_r;
    assign occupancy = occ_r;

    // Entry storage and occupancy; simultaneous push and pop keeps occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_r  <= 2'd0;
            head_r <= '0;
            tail_r <= '0;
        end else if (flush) begin
            occ_r <= 2'd0;
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10: begin
                    if (occ_r == 2'd0) begin
                        head_r <= din;
                    end else begin
                        tail_r <= din;
                    end
                    occ_r <= occ_r + 2'd1;
                end
                2'b01: begin
                    head_r <= tail_r;
                    occ_r  <= occ_r - 2'd1;
                end
                2'b11: begin
                    if (occ_r == 2'd1) begin
                        head_r <= din;
                    end else begin
                        head_r <= tail_r;
                        tail_r <= din;
                    end
                end
                default: begin
                    occ_r <= occ_r;
                end
            endcase
        end
    end

endmodule

// File: rtl/dsi_pixel_fetch.sv
// Pixel fetch: pulls one frame of words from the pixel source after each
// vsync falling edge, absorbs the source read latency in a skid buffer and
// presents a tagged valid/ready stream to the DSI packet assembler.
module dsi_pixel_fetch
    import dsi_pixel_fetch_pkg::*;
#(
    parameter int g_pixels_per_clock = 1,
    localparam int g_pixel_width = 24 * g_pixels_per_clock
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [3:0]               host_a_i,
    input  logic [31:0]              host_d_i,
    output logic [31:0]              host_d_o,
    input  logic                     host_wr_i,
    input  logic                     fifo_empty_i,
    output logic                     fifo_rd_o,
    input  logic [g_pixel_width-1:0] fifo_pixels_i,
    input  logic                     pix_vsync_i,
    output logic [g_pixel_width-1:0] pix_o,
    output logic                     pix_valid_o,
    input  logic                     pix_ready_i,
    output logic                     pix_sof_o,
    output logic                     pix_sol_o,
    output logic                     pix_eol_o,
    output logic                     pix_eof_o,
    output logic                     frame_err_o
);

    fetch_state_e state_r;
    logic         enable_r;
    logic [11:0]  xsize_r;
    logic [11:0]  ysize_r;
    logic [11:0]  xlat_r;
    logic [11:0]  ylat_r;
    logic [11:0]  wx_r;
    logic [11:0]  wy_r;
    logic         frame_err_r;
    logic [15:0]  frame_cnt_r;
    logic [25:0]  total_r;
    logic [25:0]  issued_r;
    logic         inflight_r;
    logic [31:0]  host_d_r;

    logic [1:0]                 occ_s;
    logic [1:0]                 occ_eff_s;
    logic [g_pixel_width+3:0]   head_s;
    logic [g_pixel_width+3:0]   push_data_s;
    pix_tags_t                  tags_s;
    logic                       wr_ctl_s;
    logic                       wr_xsize_s;
    logic                       wr_ysize_s;
    logic                       wr_status_s;
    logic                       enable_nxt_s;
    logic                       pop_s;
    logic                       room_s;
    logic                       rd_s;
    logic                       err_s;
    logic                       flush_s;
    logic                       last_issue_s;
    logic [12:0]                xs1_s;
    logic [12:0]                ys1_s;
    logic [25:0]                total_calc_s;

    assign wr_ctl_s    = host_wr_i && (host_a_i == REG_FETCH_CTL);
    assign wr_xsize_s  = host_wr_i && (host_a_i == REG_FETCH_XSIZE);
    assign wr_ysize_s  = host_wr_i && (host_a_i == REG_FETCH_YSIZE);
    assign wr_status_s = host_wr_i && (host_a_i == REG_FETCH_STATUS);

    // A disabling write acts on the same edge it lands, so the block is idle
    // and silent in the very next cycle.
    assign enable_nxt_s = wr_ctl_s ? host_d_i[0] : enable_r;

    assign pix_valid_o = (occ_s != 2'd0);
    assign pop_s       = pix_valid_o && pix_ready_i;

    // Room is judged after this cycle's pop so a steady stream runs at one
    // word per clock with one entry held and one read in flight.
    assign occ_eff_s = occ_s - {1'b0, pop_s};
    assign room_s    = (occ_eff_s == 2'd0) || ((occ_eff_s == 2'd1) && !inflight_r);
    assign rd_s      = (state_r == ST_FETCH) && !fifo_empty_i && room_s && (issued_r < total_r);
    assign fifo_rd_o = rd_s;

    assign last_issue_s = rd_s && ((issued_r + 26'd1) == total_r);
    assign err_s   = ((state_r == ST_FETCH) || (state_r == ST_DRAIN)) && pix_vsync_i;
    assign flush_s = err_s || !enable_nxt_s;

    assign xs1_s        = {1'b0, xsize_r} + 13'd1;
    assign ys1_s        = {1'b0, ysize_r} + 13'd1;
    assign total_calc_s = xs1_s * ys1_s;

    assign tags_s      = calc_tags(wx_r, wy_r, xlat_r, ylat_r);
    assign push_data_s = {tags_s, fifo_pixels_i};

    assign {pix_eof_o, pix_eol_o, pix_sol_o, pix_sof_o, pix_o} = head_s;
    assign frame_err_o = frame_err_r;
    assign host_d_o    = host_d_r;

    dsi_skid_buffer #(
        .g_width(g_pixel_width + 4)
    ) u_skid (
        .clk      (clk_i),
        .rst      (rst_i),
        .flush    (flush_s),
        .push     (inflight_r),
        .din      (push_data_s),
        .pop      (pop_s),
        .dout     (head_s),
        .occupancy(occ_s)
    );

    // Host-writable control, geometry and sticky error (set beats clear)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            enable_r    <= 1'b0;
            xsize_r     <= 12'd0;
            ysize_r     <= 12'd0;
            frame_err_r <= 1'b0;
        end else begin
            if (wr_ctl_s) begin
                enable_r <= host_d_i[0];
            end
            if (wr_xsize_s) begin
                xsize_r <= host_d_i[11:0];
            end
            if (wr_ysize_s) begin
                ysize_r <= host_d_i[11:0];
            end
            if (err_s) begin
                frame_err_r <= 1'b1;
            end else if (wr_status_s && host_d_i[STATUS_ERR_BIT]) begin
                frame_err_r <= 1'b0;
            end
        end
    end

    // Register readback, one cycle behind the address
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            host_d_r <= 32'd0;
        end else begin
            case (host_a_i)
                REG_FETCH_CTL:    host_d_r <= {31'd0, enable_r};
                REG_FETCH_XSIZE:  host_d_r <= {20'd0, xsize_r};
                REG_FETCH_YSIZE:  host_d_r <= {20'd0, ysize_r};
                REG_FETCH_STATUS: host_d_r <= {frame_cnt_r, 15'd0, frame_err_r};
                default:          host_d_r <= 32'd0;
            endcase
        end
    end

    // Frame sequencing, read accounting and write-side position counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            xlat_r      <= 12'd0;
            ylat_r      <= 12'd0;
            wx_r        <= 12'd0;
            wy_r        <= 12'd0;
            total_r     <= 26'd0;
            issued_r    <= 26'd0;
            inflight_r  <= 1'b0;
            frame_cnt_r <= 16'd0;
        end else begin
            inflight_r <= rd_s && !flush_s;
            if (rd_s) begin
                issued_r <= issued_r + 26'd1;
            end
            if (inflight_r) begin
                if (wx_r == xlat_r) begin
                    wx_r <= 12'd0;
                    wy_r <= wy_r + 12'd1;
                end else begin
                    wx_r <= wx_r + 12'd1;
                end
            end
            if (!enable_nxt_s) begin
                state_r <= ST_IDLE;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_WAIT_VS_HI;
                    end
                    ST_WAIT_VS_HI: begin
                        if (pix_vsync_i) begin
                            state_r <= ST_WAIT_VS_LO;
                        end
                    end
                    ST_WAIT_VS_LO: begin
                        if (!pix_vsync_i) begin
                            state_r  <= ST_FETCH;
                            xlat_r   <= xsize_r;
                            ylat_r   <= ysize_r;
                            total_r  <= total_calc_s;
                            issued_r <= 26'd0;
                            wx_r     <= 12'd0;
                            wy_r     <= 12'd0;
                        end
                    end
                    ST_FETCH: begin
                        if (pix_vsync_i) begin
                            state_r <= ST_WAIT_VS_LO;
                        end else if (last_issue_s) begin
                            state_r <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if (pix_vsync_i) begin
                            state_r <= ST_WAIT_VS_LO;
                        end else if ((occ_s == 2'd0) && !inflight_r) begin
                            state_r     <= ST_WAIT_VS_HI;
                            frame_cnt_r <= frame_cnt_r + 16'd1;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dsi_pixel_fetch.sv
// Self-checking bench for dsi_pixel_fetch: a source model hands out random
// words on each read and pushes the expected tagged word (from the word's
// index in the frame) into a queue; a monitor pops and compares on handshake.
module tb_dsi_pixel_fetch;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [3:0]  host_a_i = 4'h0;
    logic [31:0] host_d_i = 32'd0;
    logic [31:0] host_d_o;
    logic        host_wr_i = 1'b0;
    logic        fifo_empty_i = 1'b1;
    logic        fifo_rd_o;
    logic [23:0] fifo_pixels_i = 24'd0;
    logic        pix_vsync_i = 1'b0;
    logic [23:0] pix_o;
    logic        pix_valid_o;
    logic        pix_ready_i = 1'b0;
    logic        pix_sof_o, pix_sol_o, pix_eol_o, pix_eof_o;
    logic        frame_err_o;

    int total_cnt = 0;
    int bad_cnt = 0;

    logic [27:0] exp_q[$];
    int          cyc = 0;
    int          fx = 0, fy = 0, src_idx = 0;
    int          acc_cnt = 0, first_cyc = 0, last_cyc = 0;
    int          rd_count = 0;
    int          stall_at = -1, stall_left = 0;
    int          ready_mode = 0;
    bit          rand_empty = 1'b0;
    bit          vs = 1'b0;
    bit          flush_now = 1'b0;
    bit          rd_pending = 1'b0;
    logic [23:0] pend_word = 24'd0;
    bit          wr_pend = 1'b0;
    logic [3:0]  a_pend = 4'h0, rd_addr = 4'h0;
    logic [31:0] d_pend = 32'd0;
    logic        last_rd, last_valid;
    logic [31:0] last_hd;
    logic [3:0]  last_tags, last_acc_tags;
    bit          hold_prev = 1'b0;
    logic [27:0] held = 28'd0;
    int          fc = 0;

    always #5 clk = ~clk;

    dsi_pixel_fetch dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .host_a_i     (host_a_i),
        .host_d_i     (host_d_i),
        .host_d_o     (host_d_o),
        .host_wr_i    (host_wr_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_rd_o    (fifo_rd_o),
        .fifo_pixels_i(fifo_pixels_i),
        .pix_vsync_i  (pix_vsync_i),
        .pix_o        (pix_o),
        .pix_valid_o  (pix_valid_o),
        .pix_ready_i  (pix_ready_i),
        .pix_sof_o    (pix_sof_o),
        .pix_sol_o    (pix_sol_o),
        .pix_eol_o    (pix_eol_o),
        .pix_eof_o    (pix_eof_o),
        .frame_err_o  (frame_err_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total_cnt++;
        if (act !== req) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // One clock: drive inputs at negedge, observe reads at +1, flush model at +3
    task automatic step();
        int          idx, tot, xx, yy;
        logic [23:0] w;
        @(negedge clk);
        cyc++;
        fifo_pixels_i = rd_pending ? pend_word : 24'($urandom);
        rd_pending = 1'b0;
        if (stall_left > 0) begin
            fifo_empty_i = 1'b1;
            stall_left--;
        end else begin
            fifo_empty_i = rand_empty ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        case (ready_mode)
            0:       pix_ready_i = 1'b1;
            1:       pix_ready_i = 1'(cyc & 1);
            default: pix_ready_i = 1'($urandom_range(0, 1));
        endcase
        pix_vsync_i = vs;
        host_wr_i = wr_pend;
        host_a_i  = wr_pend ? a_pend : rd_addr;
        host_d_i  = d_pend;
        wr_pend   = 1'b0;
        #1;
        last_rd    = fifo_rd_o;
        last_valid = pix_valid_o;
        last_hd    = host_d_o;
        last_tags  = {pix_eof_o, pix_eol_o, pix_sol_o, pix_sof_o};
        if (fifo_rd_o) begin
            rd_count++;
            w   = 24'($urandom);
            idx = src_idx;
            src_idx++;
            tot = (fx + 1) * (fy + 1);
            check("no_overread", 64'(idx < tot), 64'd1);
            xx = idx % (fx + 1);
            yy = idx / (fx + 1);
            exp_q.push_back({(xx == fx) && (yy == fy), xx == fx, xx == 0, (xx == 0) && (yy == 0), w});
            rd_pending = 1'b1;
            pend_word  = w;
            if (src_idx == stall_at) begin
                stall_left = 5;
                stall_at   = -1;
            end
        end
        #2;
        if (flush_now) exp_q.delete();
    endtask

    task automatic host_write(input logic [3:0] a, input logic [31:0] d);
        wr_pend = 1'b1;
        a_pend  = a;
        d_pend  = d;
        step();
    endtask

    task automatic host_read(input logic [3:0] a, output logic [31:0] d);
        rd_addr = a;
        step();
        step();
        d = last_hd;
    endtask

    task automatic start_frame(input int x, input int y);
        vs = 1'b1;
        repeat (3) step();
        vs = 1'b0;
        fx = x;
        fy = y;
        src_idx = 0;
        acc_cnt = 0;
    endtask

    task automatic wait_acc(input int n);
        int k = 0;
        while (acc_cnt < n && k < 500) begin
            step();
            k++;
        end
        check("wait_acc_timeout", 64'(k < 500), 64'd1);
    endtask

    task automatic finish_frame(input int n);
        wait_acc(n);
        repeat (3) step();
        check("frame_words", 64'(acc_cnt), 64'(n));
        check("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_status(input int cnt, input logic err);
        logic [31:0] d;
        host_read(4'hB, d);
        check("status_cnt", 64'(d[31:16]), 64'(cnt));
        check("status_err", 64'(d[0]), 64'(err));
    endtask

    // Scoreboard monitor: compares each accepted word and checks stall stability
    always @(negedge clk) begin
        logic [27:0] e;
        logic [27:0] cur;
        #2;
        cur = {pix_eof_o, pix_eol_o, pix_sol_o, pix_sof_o, pix_o};
        if (hold_prev) begin
            check("stall_valid", 64'(pix_valid_o), 64'd1);
            check("stall_word", 64'(cur), 64'(held));
        end
        if (pix_valid_o && pix_ready_i && !rst_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 64'(cur), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("word_and_tags", 64'(cur), 64'(e));
            end
            acc_cnt++;
            if (acc_cnt == 1) first_cyc = cyc;
            last_cyc = cyc;
            last_acc_tags = cur[27:24];
        end
        hold_prev = pix_valid_o && !pix_ready_i && !flush_now && !rst_i;
        held = cur;
    end

    initial begin
        logic [31:0] d;
        int rc, x, y;

        // Reset state
        flush_now = 1'b1;
        rst_i = 1'b1;
        repeat (3) step();
        check("rst_rd", 64'(last_rd), 64'd0);
        check("rst_valid", 64'(last_valid), 64'd0);
        check("rst_tags", 64'(last_tags), 64'd0);
        check("rst_hostd", 64'(last_hd), 64'd0);
        check("rst_err", 64'(frame_err_o), 64'd0);
        rst_i = 1'b0;
        flush_now = 1'b0;

        // Frame A: 4x2, ready always high, full rate
        host_write(4'h9, 32'd3);
        host_write(4'hA, 32'd1);
        host_write(4'h8, 32'd1);
        start_frame(3, 1);
        finish_frame(8);
        check("full_rate_span", 64'(last_cyc - first_cyc), 64'd7);
        fc++;
        check_status(fc, 1'b0);

        // Frame B: ready toggling; geometry rewritten mid-frame for the next one
        ready_mode = 1;
        start_frame(3, 1);
        repeat (3) step();
        host_write(4'h9, 32'd7);
        host_write(4'hA, 32'd0);
        finish_frame(8);
        fc++;

        // Frame C: new 8x1 geometry, 5-cycle source stall mid-line
        ready_mode = 0;
        stall_at = 3;
        start_frame(7, 0);
        finish_frame(8);
        fc++;
        check("stall_no_err", 64'(frame_err_o), 64'd0);
        check_status(fc, 1'b0);

        // Random frames: random geometry, backpressure and source gaps
        ready_mode = 2;
        rand_empty = 1'b1;
        for (int i = 0; i < 4; i++) begin
            x = $urandom_range(0, 4);
            y = $urandom_range(0, 3);
            host_write(4'h9, 32'(x));
            host_write(4'hA, 32'(y));
            start_frame(x, y);
            finish_frame((x + 1) * (y + 1));
            fc++;
        end
        check_status(fc, 1'b0);
        ready_mode = 0;
        rand_empty = 1'b0;

        // vsync during a frame: error, flush, restart on next frame
        host_write(4'h9, 32'd3);
        host_write(4'hA, 32'd1);
        start_frame(3, 1);
        wait_acc(2);
        vs = 1'b1;
        flush_now = 1'b1;
        step();
        flush_now = 1'b0;
        step();
        check("err_set", 64'(frame_err_o), 64'd1);
        check("err_flushed", 64'(last_valid), 64'd0);
        check_status(fc, 1'b1);
        start_frame(3, 1);
        finish_frame(8);
        fc++;
        check_status(fc, 1'b1);
        host_write(4'hB, 32'd1);
        check_status(fc, 1'b0);

        // Disable mid-fetch, then re-enable with vsync low: must not fetch
        start_frame(3, 1);
        wait_acc(3);
        flush_now = 1'b1;
        host_write(4'h8, 32'd0);
        flush_now = 1'b0;
        step();
        check("dis_rd", 64'(last_rd), 64'd0);
        check("dis_valid", 64'(last_valid), 64'd0);
        host_read(4'h9, d);
        check("dis_xsize_kept", 64'(d), 64'd3);
        host_write(4'h8, 32'd1);
        rc = rd_count;
        repeat (6) step();
        check("no_fetch_without_vsync", 64'(rd_count - rc), 64'd0);
        start_frame(3, 1);
        finish_frame(8);
        fc++;
        check_status(fc, 1'b0);

        // Single-word frames carry all four tags
        host_write(4'h9, 32'd0);
        host_write(4'hA, 32'd0);
        for (int i = 0; i < 2; i++) begin
            start_frame(0, 0);
            finish_frame(1);
            check("single_tags", 64'(last_acc_tags), 64'hF);
            fc++;
        end
        check_status(fc, 1'b0);

        // Reset in the middle of a frame
        host_write(4'h9, 32'd3);
        host_write(4'hA, 32'd1);
        start_frame(3, 1);
        wait_acc(2);
        rst_i = 1'b1;
        flush_now = 1'b1;
        step();
        rst_i = 1'b0;
        flush_now = 1'b0;
        step();
        check("mrst_rd", 64'(last_rd), 64'd0);
        check("mrst_valid", 64'(last_valid), 64'd0);
        check("mrst_tags", 64'(last_tags), 64'd0);
        check("mrst_hostd", 64'(last_hd), 64'd0);
        host_read(4'h8, d);
        check("mrst_ctl", 64'(d), 64'd0);
        host_read(4'h9, d);
        check("mrst_xsize", 64'(d), 64'd0);
        check_status(0, 1'b0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
